// File: rtl/mul4_program_sequencer.sv
// Micro-sequencer running a stored register-transfer program over four W-bit registers.
// Optional perf counters (perf_evals, perf_busy) are built when MUL4_SEQ_PERF_EN is defined.
module mul4_program_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [LW-1:0] prog_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b1,
    input  logic [W-1:0]  b0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y3,
    output logic [W-1:0]  y2,
    output logic [W-1:0]  y1,
    output logic [W-1:0]  y0,
    output logic          busy,
    output logic [AW-1:0] pc
`ifdef MUL4_SEQ_PERF_EN
   ,output logic [15:0]   perf_evals,
    output logic [15:0]   perf_busy
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  r [4];
    logic [W-1:0]  ca0, ca1, cb0, cb1;
    logic [LW-1:0] len;
    logic [LW-1:0] len_in;
    logic [AW-1:0] pc_q;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    instr;
    logic [W-1:0]  src_val;
    logic [W-1:0]  res;
    logic          last;

    // Program memory has no reset so programs survive between evaluations.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE))
            mem[prog_addr] <= prog_data;
    end

    assign instr  = mem[pc_q];
    assign len_in = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    assign last   = (LW'(pc_q) == (len - LW'(1)));

    always_comb begin
        src_val = '0;
        case (instr[2:0])
            3'd0:    src_val = r[0];
            3'd1:    src_val = r[1];
            3'd2:    src_val = r[2];
            3'd3:    src_val = r[3];
            3'd4:    src_val = ca0;
            3'd5:    src_val = ca1;
            3'd6:    src_val = cb0;
            default: src_val = cb1;
        endcase
        res = r[instr[7:6]];
        case (instr[5:3])
            3'd0:    res = res & src_val;
            3'd1:    res = res | src_val;
            3'd2:    res = res ^ src_val;
            3'd3:    res = {{(W-1){1'b0}}, (src_val == '0)};
            3'd4:    res = src_val;
            default: res = r[instr[7:6]];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            for (int unsigned i = 0; i < 4; i++) r[i] <= '0;
            ca0   <= '0;
            ca1   <= '0;
            cb0   <= '0;
            cb1   <= '0;
            len   <= '0;
            pc_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        r[0]  <= a0;
                        r[1]  <= a1;
                        r[2]  <= b0;
                        r[3]  <= b1;
                        ca0   <= a0;
                        ca1   <= a1;
                        cb0   <= b0;
                        cb1   <= b1;
                        len   <= len_in;
                        pc_q  <= '0;
                        state <= (len_in != '0) ? S_EXEC : S_DONE;
                    end
                end
                S_EXEC: begin
                    r[instr[7:6]] <= res;
                    if (last) state <= S_DONE;
                    else      pc_q  <= pc_q + AW'(1);
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MUL4_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_evals <= '0;
            perf_busy  <= '0;
        end else begin
            if ((state == S_DONE) && out_ready && (perf_evals != '1))
                perf_evals <= perf_evals + 16'd1;
            if ((state == S_EXEC) && (perf_busy != '1))
                perf_busy <= perf_busy + 16'd1;
        end
    end
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_EXEC);
    assign pc        = pc_q;
    assign y0        = r[0];
    assign y1        = r[1];
    assign y2        = r[2];
    assign y3        = r[3];

endmodule

// File: tb/tb_mul4_program_sequencer.sv
// Randomized bench for mul4_program_sequencer with a transaction-level program interpreter as reference.
module tb_mul4_program_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [4:0]  prog_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a1, a0, b1, b0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y3, y2, y1, y0;
    logic        busy;
    logic [3:0]  pc;
`ifdef MUL4_SEQ_PERF_EN
    logic [15:0] perf_evals, perf_busy;
`endif

    int tests = 0;
    int fails = 0;

    mul4_program_sequencer #(.W(16), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .out_valid(out_valid), .out_ready(out_ready),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .busy(busy), .pc(pc)
`ifdef MUL4_SEQ_PERF_EN
       ,.perf_evals(perf_evals), .perf_busy(perf_busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: program memory image plus a straight interpreter of the instruction set.
    logic [7:0] mem_m [16];

    function automatic logic [63:0] model_eval(input logic [15:0] x0, x1, x2, x3, input int n);
        logic [15:0] rr [4];
        logic [15:0] sh [4];
        logic [15:0] s;
        logic [7:0]  ins;
        int d;
        rr[0] = x0; rr[1] = x1; rr[2] = x2; rr[3] = x3;
        sh[0] = x0; sh[1] = x1; sh[2] = x2; sh[3] = x3;
        for (int i = 0; i < n; i++) begin
            ins = mem_m[i];
            d   = int'(ins[7:6]);
            s   = (ins[2:0] < 3'd4) ? rr[ins[1:0]] : sh[ins[1:0]];
            case (int'(ins[5:3]))
                0: rr[d] = rr[d] & s;
                1: rr[d] = rr[d] | s;
                2: rr[d] = rr[d] ^ s;
                3: rr[d] = (s == 16'd0) ? 16'd1 : 16'd0;
                4: rr[d] = s;
                default: ;
            endcase
        end
        return {rr[3], rr[2], rr[1], rr[0]};
    endfunction

    bit          active = 0;
    int          e = 0;
    int          exp_len = 0;
    logic [63:0] exp_y = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_y", {y3, y2, y1, y0}, 64'd0);
            end else begin
                if (active) e++;
                if (!active) begin
                    chk("idle_in_ready", 64'(in_ready), 64'd1);
                    chk("idle_out_valid", 64'(out_valid), 64'd0);
                    chk("idle_busy", 64'(busy), 64'd0);
                end else begin
                    chk("run_in_ready", 64'(in_ready), 64'd0);
                    chk("run_busy", 64'(busy), 64'(e < exp_len));
                    chk("run_out_valid", 64'(out_valid), 64'(e >= exp_len));
                    if (e < exp_len) chk("run_pc", 64'(pc), 64'(e));
                    else             chk("done_y", {y3, y2, y1, y0}, exp_y);
                end
                if (!active && prog_we) mem_m[prog_addr] = prog_data;
                if (!active && in_valid) begin
                    active  = 1;
                    e       = -1;
                    exp_len = (int'(prog_len) > 16) ? 16 : int'(prog_len);
                    exp_y   = model_eval(a0, a1, b0, b1, exp_len);
                end else if (active && (e >= exp_len) && out_ready) begin
                    active = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_prog(input logic [3:0] ad, input logic [7:0] da);
        prog_we = 1'b1; prog_addr = ad; prog_data = da;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_eval(input logic [15:0] x0, x1, x2, x3, input logic [4:0] plen,
                           input int hold, input bit acc_we, input bit exec_we,
                           input bit poke_a0, output logic [63:0] res, output int lat);
        int n;
        a0 = x0; a1 = x1; b0 = x2; b1 = x3;
        prog_len  = plen;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        if (acc_we) begin
            prog_we = 1'b1; prog_addr = 4'($urandom); prog_data = 8'($urandom);
        end
        tick();
        in_valid = 1'b0;
        prog_we  = 1'b0;
        if (poke_a0) a0 = 16'hBEEF;
        n = 0;
        while (!out_valid && n < 100) begin
            if (exec_we) begin
                prog_we = 1'($urandom); prog_addr = 4'($urandom); prog_data = 8'($urandom);
            end
            tick();
            n++;
        end
        prog_we = 1'b0;
        if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
        res = {y3, y2, y1, y0};
        lat = n;
        for (int h = 0; h < hold; h++) begin
            a0 = 16'($urandom); prog_len = 5'($urandom);
            tick();
            chk("hold_y", {y3, y2, y1, y0}, res);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [63:0] res, res2;
    int          lat;

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        in_valid = 1'b0; out_ready = 1'b0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) write_prog(4'(i), 8'($urandom));

        // Basic program: r0 |= cb0; r3 ^= r3; r1 = !r3
        write_prog(4'd0, 8'h0E);
        write_prog(4'd1, 8'hD3);
        write_prog(4'd2, 8'h5B);
        do_eval(16'h00F0, 16'h0F0F, 16'h1234, 16'hFFFF, 5'd3, 0, 0, 0, 0, res, lat);
        chk("basic_y", res, 64'h0000_1234_0001_12F4);
        chk("basic_latency", 64'(lat), 64'd3);

        // len=0 pass-through with five cycles of backpressure
        do_eval(16'd1, 16'd2, 16'd3, 16'd4, 5'd0, 5, 0, 0, 0, res, lat);
        chk("pass_y", res, 64'h0004_0003_0002_0001);
        chk("pass_latency", 64'(lat), 64'd0);

        // Shadow operand: r0 = ca0 while the live a0 port changes
        write_prog(4'd0, 8'h04);
        do_eval(16'h1357, 16'h2468, 16'h0A0A, 16'h5050, 5'd1, 0, 0, 0, 1, res, lat);
        chk("shadow_y0", 64'(res[15:0]), 64'h1357);
        chk("shadow_latency", 64'(lat), 64'd1);

        // Clamp to DEPTH, then rerun with writes attempted during EXEC
        do_eval(16'hA5A5, 16'h0FF0, 16'h3C3C, 16'h8001, 5'd17, 1, 0, 0, 0, res, lat);
        chk("clamp_latency", 64'(lat), 64'd16);
        chk("clamp_y", res, model_eval(16'hA5A5, 16'h0FF0, 16'h3C3C, 16'h8001, 16));
        do_eval(16'hA5A5, 16'h0FF0, 16'h3C3C, 16'h8001, 5'd16, 0, 0, 1, 0, res2, lat);
        chk("rerun_y", res2, model_eval(16'hA5A5, 16'h0FF0, 16'h3C3C, 16'h8001, 16));
        do_eval(16'hA5A5, 16'h0FF0, 16'h3C3C, 16'h8001, 5'd16, 0, 0, 0, 0, res2, lat);
        chk("rerun_same", res2, res);

        // Reset asserted mid-EXEC
        a0 = 16'h1111; a1 = 16'h2222; b0 = 16'h3333; b1 = 16'h4444;
        prog_len = 5'd16; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_y", {y3, y2, y1, y0}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                write_prog(4'($urandom), 8'($urandom));
            do_eval(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    5'($urandom_range(0, 17)), int'($urandom_range(0, 2)),
                    1'($urandom), 1'b1, 1'b0, res, lat);
        end
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
